drop_timer: RTL and testbench

- Parametrised gravity/tick generator for the Tetris game logic.
- Emits a one-cycle `tick` pulse every P clocks, where P shrinks with game level. A soft-drop input shortens it further.
- Keeps a wrapping tick counter, which the piece-drop FSM consumes.
- Supports force-reset (new piece spawned) and, optionally, pause.

---
 rtl/drop_timer_pkg.sv | 17 +
 rtl/drop_timer_if.sv | 30 +++
 rtl/drop_period_calc.sv | 46 ++++
 rtl/drop_timer.sv | 91 +++++++++
 tb/tb_drop_timer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/drop_timer_pkg.sv
// Shared defaults for the Tetris gravity/tick generator.
// The optional pause feature is enabled by defining DROP_TIMER_PAUSE_EN.
package drop_timer_pkg;

  localparam int unsigned CLK_HZ          = 50000000;
  localparam int          DEF_CNT_W       = 32;
  localparam int          DEF_LEVEL_W     = 4;
  localparam int          DEF_TICK_W      = 3;
  localparam int unsigned DEF_BASE_PERIOD = 25000000;
  localparam int unsigned DEF_LEVEL_STEP  = 2000000;
  localparam int unsigned DEF_MIN_PERIOD  = 2500000;
  localparam int unsigned DEF_FAST_PERIOD = 2500000;

  // Highest level the level input can express.
  localparam int unsigned MAX_LEVEL = (2 ** DEF_LEVEL_W) - 1;

endpackage

// File: rtl/drop_timer_if.sv
// Control/status bundle between the game logic and the drop timer.
// master = game logic side, slave = drop_timer.
// The pause signal only has an effect when DROP_TIMER_PAUSE_EN is defined.
interface drop_timer_if
  import drop_timer_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int LEVEL_W = DEF_LEVEL_W,
  parameter int TICK_W  = DEF_TICK_W
) ();

  logic               force_reset;
  logic [LEVEL_W-1:0] level;
  logic               fast_drop;
  logic               pause;
  logic               tick;
  logic [TICK_W-1:0]  tick_count;
  logic [CNT_W-1:0]   period;

  modport master (
    output force_reset, level, fast_drop, pause,
    input  tick, tick_count, period
  );

  modport slave (
    input  force_reset, level, fast_drop, pause,
    output tick, tick_count, period
  );

endinterface

// File: rtl/drop_period_calc.sv
// Combinational period calculator: level-derived period with a MIN_PERIOD
// floor (saturating, never underflows), then capped by FAST_PERIOD while
// soft-drop is requested. Arithmetic is carried at CNT_W+LEVEL_W bits so the
// level*step product cannot wrap before the saturation test.
module drop_period_calc
  import drop_timer_pkg::*;
#(
  parameter int          CNT_W       = DEF_CNT_W,
  parameter int          LEVEL_W     = DEF_LEVEL_W,
  parameter int unsigned BASE_PERIOD = DEF_BASE_PERIOD,
  parameter int unsigned LEVEL_STEP  = DEF_LEVEL_STEP,
  parameter int unsigned MIN_PERIOD  = DEF_MIN_PERIOD,
  parameter int unsigned FAST_PERIOD = DEF_FAST_PERIOD
) (
  input  logic [LEVEL_W-1:0] level_i,
  input  logic               fast_drop_i,
  output logic [CNT_W-1:0]   period_o
);

  localparam int EXT_W = CNT_W + LEVEL_W;
  localparam logic [EXT_W-1:0] BASE_X = EXT_W'(BASE_PERIOD);
  localparam logic [EXT_W-1:0] STEP_X = EXT_W'(LEVEL_STEP);
  localparam logic [EXT_W-1:0] MIN_X  = EXT_W'(MIN_PERIOD);
  localparam logic [EXT_W-1:0] FAST_X = EXT_W'(FAST_PERIOD);

  logic [EXT_W-1:0] product;
  logic [EXT_W-1:0] diff;
  logic [EXT_W-1:0] levelPeriod;
  logic [EXT_W-1:0] effPeriod;

  // Saturating level period, then optional soft-drop cap.
  always_comb begin
    product     = EXT_W'(level_i) * STEP_X;
    diff        = BASE_X - product;
    levelPeriod = diff;
    if ((product >= BASE_X) || (diff < MIN_X)) begin
      levelPeriod = MIN_X;
    end
    effPeriod = levelPeriod;
    if (fast_drop_i && (FAST_X < levelPeriod)) begin
      effPeriod = FAST_X;
    end
    period_o = CNT_W'(effPeriod);
  end

endmodule

// File: rtl/drop_timer.sv
// Gravity tick generator: one-cycle tick every P clocks, P derived from the
// level latched at the start of each period and the live soft-drop request.
// Optional pause freezing is enabled by defining DROP_TIMER_PAUSE_EN;
// without it the pause input is ignored.
module drop_timer
  import drop_timer_pkg::*;
#(
  parameter int          CNT_W       = DEF_CNT_W,
  parameter int unsigned BASE_PERIOD = DEF_BASE_PERIOD,
  parameter int          LEVEL_W     = DEF_LEVEL_W,
  parameter int unsigned LEVEL_STEP  = DEF_LEVEL_STEP,
  parameter int unsigned MIN_PERIOD  = DEF_MIN_PERIOD,
  parameter int unsigned FAST_PERIOD = DEF_FAST_PERIOD,
  parameter int          TICK_W      = DEF_TICK_W
) (
  input logic        clk,
  input logic        rst,
  drop_timer_if.slave bus
);

  logic [CNT_W-1:0]   count_q, count_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [TICK_W-1:0]  tickCount_q, tickCount_d;
  logic               tick_q, tick_d;
  logic [CNT_W-1:0]   period;
  logic               holdState;

`ifdef DROP_TIMER_PAUSE_EN
  assign holdState = bus.pause;
`else
  logic unusedPause;
  assign unusedPause = bus.pause;
  assign holdState   = 1'b0;
`endif

  drop_period_calc #(
    .CNT_W       (CNT_W),
    .LEVEL_W     (LEVEL_W),
    .BASE_PERIOD (BASE_PERIOD),
    .LEVEL_STEP  (LEVEL_STEP),
    .MIN_PERIOD  (MIN_PERIOD),
    .FAST_PERIOD (FAST_PERIOD)
  ) u_periodCalc (
    .level_i     (level_q),
    .fast_drop_i (bus.fast_drop),
    .period_o    (period)
  );

  // Next-state: force_reset beats pause beats counting; >= lets a shrunken
  // period (late soft-drop) expire on the very next edge.
  always_comb begin
    count_d     = count_q;
    tick_d      = 1'b0;
    tickCount_d = tickCount_q;
    level_d     = level_q;
    if (bus.force_reset) begin
      count_d     = '0;
      tickCount_d = '0;
      level_d     = bus.level;
    end else if (holdState) begin
      tick_d = 1'b0;
    end else if (count_q >= (period - CNT_W'(1))) begin
      count_d     = '0;
      tick_d      = 1'b1;
      tickCount_d = tickCount_q + 1'b1;
      level_d     = bus.level;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q     <= '0;
      tick_q      <= 1'b0;
      tickCount_q <= '0;
      level_q     <= '0;
    end else begin
      count_q     <= count_d;
      tick_q      <= tick_d;
      tickCount_q <= tickCount_d;
      level_q     <= level_d;
    end
  end

  assign bus.tick       = tick_q;
  assign bus.tick_count = tickCount_q;
  assign bus.period     = period;

endmodule

// File: tb/tb_drop_timer.sv
// Bench for drop_timer with small periods (BASE=10, STEP=2, MIN=3, FAST=2).
// Expected tick/tick_count/period per cycle come from a segment table.
// Pause expectations follow DROP_TIMER_PAUSE_EN.
module tb_drop_timer;

  localparam int CNT_W   = 32;
  localparam int LEVEL_W = 4;
  localparam int TICK_W  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  drop_timer_if #(.CNT_W(CNT_W), .LEVEL_W(LEVEL_W), .TICK_W(TICK_W)) dtIf ();

  drop_timer #(
    .CNT_W       (CNT_W),
    .BASE_PERIOD (10),
    .LEVEL_W     (LEVEL_W),
    .LEVEL_STEP  (2),
    .MIN_PERIOD  (3),
    .FAST_PERIOD (2),
    .TICK_W      (TICK_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (dtIf.slave)
  );

  typedef struct {
    bit         rstN;
    bit         forceRst;
    logic [3:0] level;
    bit         fast;
    bit         pause;
    int         cycles;
    int         firstTick;
    int         spacing;
    int         perBefore;
    int         perAfter;
  } segT;

  typedef struct {
    bit tick;
    int tc;
    int period;
    int seg;
    int cyc;
  } expT;

  segT segs[$];
  expT expQ[$];
  int  errors = 0;
  int  checks = 0;
  int  tcExp  = 0;

  function automatic segT mkSeg(bit rstN, bit forceRst, logic [3:0] level, bit fast,
                                bit pause, int cycles, int firstTick, int spacing,
                                int perBefore, int perAfter);
    segT s;
    s.rstN = rstN; s.forceRst = forceRst; s.level = level; s.fast = fast;
    s.pause = pause; s.cycles = cycles; s.firstTick = firstTick;
    s.spacing = spacing; s.perBefore = perBefore; s.perAfter = perAfter;
    return s;
  endfunction

  // Pop the oldest expectation and compare with the DUT outputs.
  task automatic checkOutput();
    expT e;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: output with no expectation queued");
      return;
    end
    e = expQ.pop_front();
    if (dtIf.tick !== e.tick || dtIf.tick_count !== TICK_W'(e.tc) ||
        dtIf.period !== CNT_W'(e.period)) begin
      errors++;
      $display("[TB] FAIL seg%0d cyc%0d: got tick=%0b tc=%0d period=%0d, want tick=%0b tc=%0d period=%0d",
               e.seg, e.cyc, dtIf.tick, dtIf.tick_count, dtIf.period, e.tick, e.tc, e.period);
    end
  endtask

  // Drive one segment, queue the expected outputs for every edge, check.
  task automatic applyStimulus(input segT s, input int idx);
    rst              = s.rstN;
    dtIf.force_reset = s.forceRst;
    dtIf.level       = s.level;
    dtIf.fast_drop   = s.fast;
    dtIf.pause       = s.pause;
    for (int k = 1; k <= s.cycles; k++) begin
      expT e;
      bit  t;
      t = (s.firstTick > 0) && (k >= s.firstTick) && (((k - s.firstTick) % s.spacing) == 0);
      if (!s.rstN || s.forceRst) tcExp = 0;
      else if (t) tcExp = (tcExp + 1) % 8;
      e.tick   = t;
      e.tc     = tcExp;
      e.period = ((s.firstTick > 0) && (k >= s.firstTick)) ? s.perAfter : s.perBefore;
      e.seg    = idx;
      e.cyc    = k;
      expQ.push_back(e);
      @(posedge clk);
      #1;
      checkOutput();
    end
  endtask

  // Count edges until the next tick; -1 if it never comes.
  task automatic waitTick(input int maxCycles, output int n);
    n = -1;
    for (int i = 1; i <= maxCycles; i++) begin
      @(posedge clk);
      #1;
      if (dtIf.tick === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic checkInterval(input string name, input int expCycles);
    int n;
    waitTick(40, n);
    checks++;
    if (n != expCycles) begin
      errors++;
      $display("[TB] FAIL %s: tick after %0d cycles, want %0d", name, n, expCycles);
    end
  endtask

  initial begin
    dtIf.force_reset = 1'b0;
    dtIf.level       = '0;
    dtIf.fast_drop   = 1'b0;
    dtIf.pause       = 1'b0;

    //                  rstN frc lvl fast pau cyc first sp  pB  pA
    segs.push_back(mkSeg(0, 0, 4'd0,  0, 0,  2,  0,  1, 10, 10)); // reset
    segs.push_back(mkSeg(1, 0, 4'd0,  0, 0, 80, 10, 10, 10, 10)); // base period, tc wrap
    segs.push_back(mkSeg(1, 0, 4'd3,  0, 0, 18, 10,  4, 10,  4)); // level 3 at next tick
    segs.push_back(mkSeg(1, 0, 4'd15, 0, 0, 10,  4,  3,  4,  3)); // level 15 saturates
    segs.push_back(mkSeg(1, 1, 4'd0,  0, 0,  1,  0,  1, 10, 10)); // force back to level 0
    segs.push_back(mkSeg(1, 0, 4'd0,  0, 0,  6,  0,  1, 10, 10)); // count reaches 6
    segs.push_back(mkSeg(1, 0, 4'd0,  1, 0,  7,  1,  2,  2,  2)); // late fast_drop
    segs.push_back(mkSeg(1, 0, 4'd0,  0, 0, 20, 10, 10, 10, 10)); // fast_drop released
    segs.push_back(mkSeg(1, 0, 4'd0,  0, 0,  9,  0,  1, 10, 10)); // count reaches 9
    segs.push_back(mkSeg(1, 1, 4'd0,  0, 0,  1,  0,  1, 10, 10)); // force on tick edge
    segs.push_back(mkSeg(1, 0, 4'd0,  0, 0, 10, 10, 10, 10, 10)); // tick 10 later
    segs.push_back(mkSeg(1, 1, 4'd0,  0, 0, 20,  0,  1, 10, 10)); // force held
    segs.push_back(mkSeg(1, 0, 4'd0,  0, 0, 10, 10, 10, 10, 10));
    segs.push_back(mkSeg(1, 0, 4'd0,  0, 0,  4,  0,  1, 10, 10)); // count reaches 4
`ifdef DROP_TIMER_PAUSE_EN
    segs.push_back(mkSeg(1, 0, 4'd0,  0, 1,  7,  0,  1, 10, 10)); // paused
    segs.push_back(mkSeg(1, 0, 4'd0,  0, 0, 10,  6, 10, 10, 10)); // resume
`else
    segs.push_back(mkSeg(1, 0, 4'd0,  0, 1,  7,  6, 10, 10, 10)); // pause ignored
    segs.push_back(mkSeg(1, 0, 4'd0,  0, 0, 10,  9, 10, 10, 10));
`endif
    segs.push_back(mkSeg(1, 1, 4'd0,  0, 0,  1,  0,  1, 10, 10)); // clean restart
    segs.push_back(mkSeg(1, 0, 4'd0,  0, 0, 57, 10, 10, 10, 10)); // count 7, tc 5
    segs.push_back(mkSeg(0, 0, 4'd0,  0, 0,  1,  0,  1, 10, 10)); // mid-operation reset
    segs.push_back(mkSeg(1, 0, 4'd0,  0, 0, 10, 10, 10, 10, 10)); // tick 10 after release

    foreach (segs[i]) applyStimulus(segs[i], i);

    // Hand sequence: force_reset latches level 3, then soft-drop toggling.
    dtIf.level       = 4'd3;
    dtIf.force_reset = 1'b1;
    @(posedge clk);
    #1;
    dtIf.force_reset = 1'b0;
    checkInterval("lvl3_first", 4);
    checkInterval("lvl3_second", 4);
    dtIf.fast_drop = 1'b1;
    checkInterval("fast_first", 2);
    checkInterval("fast_second", 2);
    dtIf.fast_drop = 1'b0;
    dtIf.level     = 4'd0;
    checkInterval("fast_release", 4);
    checkInterval("lvl0_restored", 10);

    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d left, want 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
